// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared word length and MEM-stage sequencer state encoding
package mem_access_ctrl_pkg;

    localparam int MEM_WORD_LEN = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_timeout_cnt.sv
// rtl/mem_timeout_cnt.sv - ACCESS-cycle counter flagging the last permitted wait cycle
module mem_timeout_cnt #(
    parameter int LIMIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_expired
);

    localparam int CNT_W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

    logic [CNT_W-1:0] r_count;

    // Expired during the LIMIT-th enabled cycle so the caller can leave on that edge.
    assign o_expired = i_enable && (r_count == CNT_W'(LIMIT - 1));

    // Restart on each new access, count while the access is outstanding.
    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_count <= '0;
        end else if (i_enable && !o_expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM-stage SRAM req/ack sequencer with pipeline freeze; optional MEM_TIMEOUT_EN
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int WORD_LEN       = MEM_WORD_LEN,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                MEM_R_EN_IN,
    input  logic                MEM_W_EN_IN,
    input  logic                WB_EN_IN,
    input  logic [WORD_LEN-1:0] ALUResIn,
    input  logic [WORD_LEN-1:0] storeValIn,
    input  logic                sram_ack,
    input  logic [WORD_LEN-1:0] sram_rdata,
    output logic                freeze,
    output logic                WB_EN,
    output logic [WORD_LEN-1:0] memReadVal,
    output logic                sram_req,
    output logic                sram_we,
    output logic [WORD_LEN-1:0] sram_addr,
    output logic [WORD_LEN-1:0] sram_wdata,
    output logic                mem_err
);

    mem_state_t          r_state;
    mem_state_t          w_state_next;
    logic                w_mem_req;
    logic                w_issue;
    logic                w_in_access;
    logic                w_timeout;
    logic                r_req;
    logic                r_we;
    logic [WORD_LEN-1:0] r_addr;
    logic [WORD_LEN-1:0] r_wdata;
    logic [WORD_LEN-1:0] r_rdata;
    logic                r_mem_err;

    assign w_mem_req   = MEM_R_EN_IN | MEM_W_EN_IN;
    assign w_issue     = (r_state == ST_IDLE) & w_mem_req;
    assign w_in_access = (r_state == ST_ACCESS);

`ifdef MEM_TIMEOUT_EN
    logic w_expired;

    mem_timeout_cnt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .i_clear  (w_issue),
        .i_enable (w_in_access),
        .o_expired(w_expired)
    );

    // An ack arriving on the limit cycle is a normal completion.
    assign w_timeout = w_in_access & w_expired & ~sram_ack;
`else
    assign w_timeout = 1'b0;
`endif

    // Stall combinationally in the issuing cycle so EX/MEM holds the instruction.
    assign freeze     = w_issue | w_in_access;
    assign WB_EN      = WB_EN_IN & ~freeze;
    assign memReadVal = r_rdata;
    assign sram_req   = r_req;
    assign sram_we    = r_we;
    assign sram_addr  = r_addr;
    assign sram_wdata = r_wdata;
    assign mem_err    = r_mem_err;

    // State register; reset abandons any outstanding access.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: issue, wait for ack (or timeout), one DONE cycle to let the instruction advance.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_mem_req) w_state_next = ST_ACCESS;
            ST_ACCESS: if (sram_ack || w_timeout) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // SRAM request registers, captured load data and the one-cycle error flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_req     <= 1'b0;
            r_we      <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_mem_err <= 1'b0;
        end else begin
            r_mem_err <= 1'b0;
            if (w_issue) begin
                r_addr  <= ALUResIn;
                r_wdata <= storeValIn;
                r_we    <= ~MEM_R_EN_IN;
                r_req   <= 1'b1;
            end else if (w_in_access) begin
                if (sram_ack) begin
                    r_req <= 1'b0;
                    if (!r_we) begin
                        r_rdata <= sram_rdata;
                    end
                end else if (w_timeout) begin
                    r_req     <= 1'b0;
                    r_rdata   <= '0;
                    r_mem_err <= 1'b1;
                end
            end
        end
    end

endmodule
